// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants, error codes, parser states and digit helpers for the UART command decoder.
// Used by uart_cmd_decoder and, when UART_CMD_ACK_EN is defined, uart_ack_sender.
package uart_cmd_pkg;

    localparam logic [7:0] CH_X   = 8'h58;
    localparam logic [7:0] CH_O   = 8'h4F;
    localparam logic [7:0] CH_N   = 8'h4E;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_ACK = 8'h4B;
    localparam logic [7:0] CH_NAK = 8'h45;

    typedef enum logic [1:0] {
        BAD_CMD   = 2'd0,
        BAD_DIGIT = 2'd1,
        NO_TERM   = 2'd2,
        TIMEOUT   = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ROW  = 3'd1,
        ST_GET_COL  = 3'd2,
        ST_GET_END  = 3'd3,
        ST_GET_NEND = 3'd4
    } parser_state_t;

    function automatic logic is_coord_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h32);
    endfunction

    // Only meaningful for '0'..'2', where the low two bits are the value.
    function automatic logic [1:0] coord_value(input logic [7:0] b);
        return b[1:0];
    endfunction

    function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] row4;
        row4 = {2'b00, row};
        return (row4 * 4'd3) + {2'b00, col};
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_ack_sender.sv
// Ack byte sender toward uart_tx: a one-deep pending slot feeds an IDLE/SEND/WAIT_DONE handshake.
// Instantiated only when UART_CMD_ACK_EN is defined.
module uart_ack_sender
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [7:0] req_byte,
    input  logic       tx_done,
    output logic       tx_data_valid,
    output logic [7:0] tx_byte
);

    localparam logic [1:0] AS_IDLE      = 2'd0;
    localparam logic [1:0] AS_SEND      = 2'd1;
    localparam logic [1:0] AS_WAIT_DONE = 2'd2;

    logic [1:0] state_r;
    logic       pending_r;
    logic [7:0] pending_byte_r;
    logic       tx_data_valid_r;
    logic [7:0] tx_byte_r;

    // Pending slot: a fresh request always wins over an unsent older one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r      <= 1'b0;
            pending_byte_r <= 8'h00;
        end else if (req_valid) begin
            pending_r      <= 1'b1;
            pending_byte_r <= req_byte;
        end else if ((state_r == AS_IDLE) && pending_r) begin
            pending_r      <= 1'b0;
        end else begin
            pending_r      <= pending_r;
        end
    end

    // Handshake FSM: one-cycle tx_data_valid, then hold until uart_tx reports done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= AS_IDLE;
            tx_data_valid_r <= 1'b0;
            tx_byte_r       <= 8'h00;
        end else begin
            tx_data_valid_r <= 1'b0;
            case (state_r)
                AS_IDLE: begin
                    if (pending_r) begin
                        tx_data_valid_r <= 1'b1;
                        tx_byte_r       <= pending_byte_r;
                        state_r         <= AS_SEND;
                    end else begin
                        state_r         <= AS_IDLE;
                    end
                end
                AS_SEND:      state_r <= tx_done ? AS_IDLE : AS_WAIT_DONE;
                AS_WAIT_DONE: state_r <= tx_done ? AS_IDLE : AS_WAIT_DONE;
                default:      state_r <= AS_IDLE;
            endcase
        end
    end

    assign tx_data_valid = tx_data_valid_r;
    assign tx_byte       = tx_byte_r;

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII move / new-game frame parser with registered strobes and an inter-byte timeout.
// Define UART_CMD_ACK_EN to add the 'K'/'E' acknowledgement path toward uart_tx.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_data_valid,
    input  logic [7:0] rx_byte,
    output logic       move_valid,
    output logic       move_player,
    output logic [3:0] move_cell,
    output logic       new_game,
    output logic       cmd_error,
    output logic [1:0] err_code,
    output logic       busy
`ifdef UART_CMD_ACK_EN
    ,
    output logic       tx_data_valid,
    output logic [7:0] tx_byte,
    input  logic       tx_done
`endif
);

    localparam int TO_LIMIT = CLKS_PER_BIT * TIMEOUT_BITS;
    localparam int CW       = $clog2(TO_LIMIT);
    localparam logic [CW-1:0] CNT_TERM = CW'(TO_LIMIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    parser_state_t state_r, next_state_s;
    logic          player_r, next_player_s;
    logic [1:0]    row_r, next_row_s;
    logic [1:0]    col_r, next_col_s;
    logic [CW-1:0] cnt_r;
    logic          move_s, new_game_s, err_s;
    err_code_t     err_code_s;

    logic          move_valid_r, move_player_r, new_game_r, cmd_error_r;
    logic [3:0]    move_cell_r;
    err_code_t     err_code_r;

    // Frame decode: what this cycle's byte (or the expiring timer) does to the parser.
    always_comb begin
        next_state_s  = state_r;
        next_player_s = player_r;
        next_row_s    = row_r;
        next_col_s    = col_r;
        move_s        = 1'b0;
        new_game_s    = 1'b0;
        err_s         = 1'b0;
        err_code_s    = BAD_CMD;
        if (rx_data_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if ((rx_byte == CH_X) || (rx_byte == CH_O)) begin
                        next_player_s = (rx_byte == CH_O);
                        next_state_s  = ST_GET_ROW;
                    end else if (rx_byte == CH_N) begin
                        next_state_s  = ST_GET_NEND;
                    end else if ((rx_byte == CH_CR) || (rx_byte == CH_LF)) begin
                        next_state_s  = ST_IDLE;
                    end else begin
                        err_s         = 1'b1;
                        err_code_s    = BAD_CMD;
                    end
                end
                ST_GET_ROW: begin
                    if (is_coord_digit(rx_byte)) begin
                        next_row_s   = coord_value(rx_byte);
                        next_state_s = ST_GET_COL;
                    end else begin
                        err_s        = 1'b1;
                        err_code_s   = BAD_DIGIT;
                        next_state_s = ST_IDLE;
                    end
                end
                ST_GET_COL: begin
                    if (is_coord_digit(rx_byte)) begin
                        next_col_s   = coord_value(rx_byte);
                        next_state_s = ST_GET_END;
                    end else begin
                        err_s        = 1'b1;
                        err_code_s   = BAD_DIGIT;
                        next_state_s = ST_IDLE;
                    end
                end
                ST_GET_END: begin
                    if (rx_byte == CH_CR) begin
                        move_s       = 1'b1;
                    end else begin
                        err_s        = 1'b1;
                        err_code_s   = NO_TERM;
                    end
                    next_state_s = ST_IDLE;
                end
                ST_GET_NEND: begin
                    if (rx_byte == CH_CR) begin
                        new_game_s   = 1'b1;
                    end else begin
                        err_s        = 1'b1;
                        err_code_s   = NO_TERM;
                    end
                    next_state_s = ST_IDLE;
                end
                default: next_state_s = ST_IDLE;
            endcase
        end else if ((state_r != ST_IDLE) && (cnt_r == CNT_TERM)) begin
            err_s        = 1'b1;
            err_code_s   = TIMEOUT;
            next_state_s = ST_IDLE;
        end else begin
            next_state_s = state_r;
        end
    end

    // Parser state and latched frame fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            player_r <= 1'b0;
            row_r    <= 2'd0;
            col_r    <= 2'd0;
        end else begin
            state_r  <= next_state_s;
            player_r <= next_player_s;
            row_r    <= next_row_s;
            col_r    <= next_col_s;
        end
    end

    // Inter-byte timer; a byte arriving on the terminal count takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (rx_data_valid || (state_r == ST_IDLE) || err_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Registered output strobes; move fields and err_code hold between events.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            move_valid_r  <= 1'b0;
            move_player_r <= 1'b0;
            move_cell_r   <= 4'd0;
            new_game_r    <= 1'b0;
            cmd_error_r   <= 1'b0;
            err_code_r    <= BAD_CMD;
        end else begin
            move_valid_r <= move_s;
            new_game_r   <= new_game_s;
            cmd_error_r  <= err_s;
            if (move_s) begin
                move_player_r <= player_r;
                move_cell_r   <= cell_index(row_r, col_r);
            end else begin
                move_player_r <= move_player_r;
                move_cell_r   <= move_cell_r;
            end
            if (err_s) begin
                err_code_r <= err_code_s;
            end else begin
                err_code_r <= err_code_r;
            end
        end
    end

    assign move_valid  = move_valid_r;
    assign move_player = move_player_r;
    assign move_cell   = move_cell_r;
    assign new_game    = new_game_r;
    assign cmd_error   = cmd_error_r;
    assign err_code    = err_code_r;
    assign busy        = (state_r != ST_IDLE);

`ifdef UART_CMD_ACK_EN
    logic       ack_req_s;
    logic [7:0] ack_byte_s;

    assign ack_req_s  = move_valid_r | new_game_r | cmd_error_r;
    assign ack_byte_s = cmd_error_r ? CH_NAK : CH_ACK;

    uart_ack_sender u_ack_sender (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (ack_req_s),
        .req_byte      (ack_byte_s),
        .tx_done       (tx_done),
        .tx_data_valid (tx_data_valid),
        .tx_byte       (tx_byte)
    );
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed + randomized bench for uart_cmd_decoder against a frame-level reference model.
// Ack path checks are compiled in when UART_CMD_ACK_EN is defined.
module tb_uart_cmd_decoder;

    localparam int LIMIT = 868 * 20;
    localparam logic [7:0] B_X = 8'h58, B_O = 8'h4F, B_N = 8'h4E, B_CR = 8'h0D, B_LF = 8'h0A;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_data_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       move_valid, move_player, new_game, cmd_error, busy;
    logic [3:0] move_cell;
    logic [1:0] err_code;
`ifdef UART_CMD_ACK_EN
    logic       tx_data_valid;
    logic [7:0] tx_byte;
    logic       tx_done = 1'b0;
    logic [7:0] last_tx = 8'h00;
`endif

    uart_cmd_decoder #(.CLKS_PER_BIT(868), .TIMEOUT_BITS(20)) dut (
        .clk(clk), .reset(reset), .rx_data_valid(rx_data_valid), .rx_byte(rx_byte),
        .move_valid(move_valid), .move_player(move_player), .move_cell(move_cell),
        .new_game(new_game), .cmd_error(cmd_error), .err_code(err_code), .busy(busy)
`ifdef UART_CMD_ACK_EN
        , .tx_data_valid(tx_data_valid), .tx_byte(tx_byte), .tx_done(tx_done)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the bytes of the frame in progress plus the expected outputs.
    logic [7:0] frame[$];
    logic       exp_mv = 1'b0, exp_ng = 1'b0, exp_err = 1'b0, exp_player = 1'b0;
    logic [1:0] exp_code = 2'd0;
    logic [3:0] exp_cell = 4'd0;

    function automatic void clear_strobes();
        exp_mv  = 1'b0;
        exp_ng  = 1'b0;
        exp_err = 1'b0;
    endfunction

    function automatic void reject(input logic [1:0] code);
        exp_err  = 1'b1;
        exp_code = code;
        frame.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        clear_strobes();
        if (frame.size() == 0) begin
            if (b == B_X || b == B_O || b == B_N) frame.push_back(b);
            else if (b == B_CR || b == B_LF) begin end
            else reject(2'd0);
        end else if (frame[0] == B_N) begin
            if (b == B_CR) begin exp_ng = 1'b1; frame.delete(); end
            else reject(2'd2);
        end else if (frame.size() < 3) begin
            if (b >= 8'h30 && b <= 8'h32) frame.push_back(b);
            else reject(2'd1);
        end else begin
            if (b == B_CR) begin
                exp_mv     = 1'b1;
                exp_player = (frame[0] == B_O);
                exp_cell   = 4'(3 * (int'(frame[1]) - 48) + (int'(frame[2]) - 48));
                frame.delete();
            end else reject(2'd2);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ":move_valid"},  32'(move_valid),  32'(exp_mv));
        chk({ctx, ":new_game"},    32'(new_game),    32'(exp_ng));
        chk({ctx, ":cmd_error"},   32'(cmd_error),   32'(exp_err));
        chk({ctx, ":move_player"}, 32'(move_player), 32'(exp_player));
        chk({ctx, ":move_cell"},   32'(move_cell),   32'(exp_cell));
        chk({ctx, ":busy"},        32'(busy),        32'(frame.size() != 0));
        if (exp_err) chk({ctx, ":err_code"}, 32'(err_code), 32'(exp_code));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data_valid = 1'b1;
        rx_byte       = b;
        model_byte(b);
        @(posedge clk);
        #1 check_outputs("byte");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_data_valid = 1'b0;
            rx_byte       = 8'($urandom);
            clear_strobes();
            @(posedge clk);
            #1 check_outputs("idle");
        end
    endtask

    task automatic quiet(input int n);
        clear_strobes();
        repeat (n) begin
            @(negedge clk);
            rx_data_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input int len);
        logic [7:0] bytes [4];
        bytes = '{a, b, c, d};
        for (int i = 0; i < len; i++) begin
            send_byte(bytes[i]);
            idle($urandom_range(0, 2));
        end
    endtask

`ifdef UART_CMD_ACK_EN
    // uart_tx stand-in: capture the byte and report done a few cycles later.
    initial forever begin
        @(posedge clk);
        #1;
        if (tx_data_valid) begin
            last_tx = tx_byte;
            repeat (3) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    end
`endif

    logic [7:0] pool [16];

    initial begin
        pool = '{B_X, B_O, B_N, B_CR, B_LF, 8'h30, 8'h31, 8'h32,
                 8'h33, 8'h51, 8'h2F, B_X, B_O, 8'h31, B_CR, 8'h7A};

        // Reset state
        repeat (2) @(posedge clk);
        #1 check_outputs("reset");
        chk("reset:err_code", 32'(err_code), 32'd0);
`ifdef UART_CMD_ACK_EN
        chk("reset:tx_data_valid", 32'(tx_data_valid), 32'd0);
        chk("reset:tx_byte", 32'(tx_byte), 32'd0);
`endif
        @(negedge clk) reset = 1'b1;
        idle(2);

        send_frame(B_X, 8'h31, 8'h32, B_CR, 4);     idle(2);
        send_frame(B_O, 8'h30, 8'h30, B_CR, 4);
        send_frame(B_N, B_CR, 8'h00, 8'h00, 2);     idle(2);
        send_frame(B_X, 8'h33, 8'h00, 8'h00, 2);
        send_frame(B_X, 8'h32, 8'h32, B_CR, 4);
        send_frame(8'h51, 8'h00, 8'h00, 8'h00, 1);
        send_frame(B_N, B_X, 8'h31, 8'h00, 3);      // 'X' is dropped, so '1' is a bad command
        send_frame(B_CR, B_LF, B_CR, 8'h00, 3);     idle(2);
        send_frame(B_X, B_CR, 8'h00, 8'h00, 2);     // CR in place of a digit

        // Timeout exactly at the terminal count
        send_byte(B_X);
        send_byte(8'h31);
        quiet(LIMIT - 1);
        #1 check_outputs("pre_timeout");
        @(negedge clk);
        frame.delete();
        exp_err  = 1'b1;
        exp_code = 2'd3;
        @(posedge clk);
        #1 check_outputs("timeout");
        idle(2);

        // Byte landing on the terminal count wins over the timeout
        send_byte(B_X);
        send_byte(8'h31);
        quiet(LIMIT - 1);
        send_byte(8'h32);
        send_byte(B_CR);
        idle(12);

`ifdef UART_CMD_ACK_EN
        begin
            logic seen;
            logic [7:0] got;
            seen = 1'b0;
            got  = 8'h00;
            send_frame(B_X, 8'h31, 8'h31, B_CR, 4);
            @(negedge clk) rx_data_valid = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(posedge clk);
                #1;
                if (tx_data_valid) begin seen = 1'b1; got = tx_byte; end
            end
            chk("ack:tx_data_valid", 32'(seen), 32'd1);
            chk("ack:tx_byte", 32'(got), 32'h4B);
            quiet(8);
            chk("ack:loopback", 32'(last_tx), 32'h4B);
            idle(2);
        end
`endif

        // Asynchronous reset in the middle of a frame
        send_byte(B_O);
        send_byte(8'h31);
        #2 reset = 1'b0;
        rx_data_valid = 1'b0;
        frame.delete();
        clear_strobes();
        exp_player = 1'b0;
        exp_cell   = 4'd0;
        #1 check_outputs("midreset");
        @(negedge clk) reset = 1'b1;
        idle(4);

        // Randomized mix of well-formed frames and arbitrary bytes
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: send_frame($urandom_range(0, 1) ? B_O : B_X, 8'(8'h30 + $urandom_range(0, 2)),
                              8'(8'h30 + $urandom_range(0, 2)), B_CR, 4);
                1: send_frame(B_N, B_CR, 8'h00, 8'h00, 2);
                default: begin
                    send_byte(pool[$urandom_range(0, 15)]);
                    idle($urandom_range(0, 2));
                end
            endcase
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Receive-side command parser for the tic-tac-toe UART link. It consumes bytes from uart_rx (rx_data_valid/rx_byte), parses ASCII move and new-game frames, and emits single-cycle move and new-game strobes to the game controller. Malformed or stalled frames raise a coded error pulse.

Parameters:
CLKS_PER_BIT, 868, clocks per UART bit; matches uart_rx/uart_tx.
TIMEOUT_BITS, 20, inter-byte timeout in bit periods. Limit is CLKS_PER_BIT*TIMEOUT_BITS clocks.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-low
rx_data_valid  input  1  one-cycle strobe; rx_byte is valid this cycle
rx_byte  input  8  received byte
move_valid  output  1  one-cycle strobe; a complete move frame was accepted
move_player  output  1  0 = X, 1 = O; valid with move_valid
move_cell  output  4  row*3+col, 0..8; valid with move_valid
new_game  output  1  one-cycle strobe; a new-game frame was accepted
cmd_error  output  1  one-cycle strobe; a frame was rejected
err_code  output  2  0 BAD_CMD, 1 BAD_DIGIT, 2 NO_TERM, 3 TIMEOUT; valid with cmd_error
busy  output  1  high while a frame is partially received (state != IDLE)

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; timeout counter 0.
- Frames:
  - Move frame: 'X'(0x58) or 'O'(0x4F), row '0'-'2', col '0'-'2', then CR (0x0D).
  - New-game frame: 'N'(0x4E) then CR.
- Only cycles with rx_data_valid=1 advance the parser.
- FSM states: IDLE, GET_ROW, GET_COL, GET_END, GET_NEND.
  - IDLE:
    - 'X'/'O': latch player, go to GET_ROW.
    - 'N': go to GET_NEND.
    - CR or LF (0x0A): ignored silently.
    - Any other byte: BAD_CMD error.
  - GET_ROW: '0'-'2' latches row and goes to GET_COL. Any other byte: BAD_DIGIT.
  - GET_COL: '0'-'2' latches col and goes to GET_END. Any other byte: BAD_DIGIT.
  - GET_END: CR gives move_valid=1 on the next cycle, with move_cell=row*3+col, then IDLE. Any other byte: NO_TERM.
  - GET_NEND: CR gives new_game=1 on the next cycle, then IDLE. Any other byte: NO_TERM.
- Latency: strobes are registered and appear exactly 1 clk after the terminating byte's rx_data_valid cycle.
- Strobes last exactly one cycle.
- move_cell and move_player hold their last values between strobes.
- Errors:
  - cmd_error=1 with err_code for exactly one cycle, 1 clk after the detecting event.
  - State returns to IDLE.
  - The offending byte is discarded, never re-parsed as a frame start.
- Timeout counter:
  - Clears on every rx_data_valid and whenever the state is IDLE.
  - Increments each clk while not IDLE.
  - On reaching CLKS_PER_BIT*TIMEOUT_BITS-1: TIMEOUT error, return to IDLE.
  - If rx_data_valid coincides with the terminal count, the byte is processed and no timeout is raised.
- Row/col arithmetic: cell = row*3+col, computed in 4 bits with the maximum value 8. Digits are bytes minus 0x30.
- move_valid, new_game and cmd_error are mutually exclusive by construction.
- Mid-frame reset: async abort; no strobes are emitted for the partial frame.
- busy=1 in every state except IDLE, combinational from the state register.

Optional Feature:
Macro UART_CMD_ACK_EN.
- Defined:
  - Adds ports: tx_data_valid output 1, tx_byte output 8, tx_done input 1. These connect to uart_tx.
  - After each move_valid or new_game, the block sends 'K' (0x4B). After each cmd_error, it sends 'E' (0x45).
  - Send handshake: assert tx_data_valid for one cycle with tx_byte set, then wait for tx_done.
  - One-deep pending register: a newer ack request overwrites an unsent pending one.
  - Parsing is never blocked by an ack in flight.
  - Reset: tx_data_valid=0, tx_byte=0, pending cleared.
- Undefined: no tx ports and no ack logic; behaviour is otherwise identical.

Decomposition:
- Package uart_cmd_pkg holds:
  - ASCII constants: CH_X, CH_O, CH_N, CH_CR, CH_LF, CH_ACK, CH_NAK.
  - typedef enum err_code_t {BAD_CMD, BAD_DIGIT, NO_TERM, TIMEOUT}.
  - The parser state enum.
- One natural sub-module: uart_ack_sender. It holds the ack FSM (IDLE, SEND, WAIT_DONE) and is instantiated only under UART_CMD_ACK_EN.

Test Plan:
- Bytes 'X','1','2',CR (uart_rx loopback, CLKS_PER_BIT=868): one move_valid pulse with move_player=0, move_cell=5. busy is low afterwards.
- Bytes 'O','0','0',CR, then 'N',CR: move_valid with player=1, cell=0; then one new_game pulse. No cmd_error.
- Bytes 'X','3': cmd_error with err_code=1, state IDLE. A subsequent 'X','2','2',CR gives move_cell=8.
- Bytes 'X','1' then silence for 20*868 clks: cmd_error with err_code=3 at the terminal count. No move_valid.
- Byte 'Q': err_code=0. Bytes 'N','X': err_code=2. Lone CR/LF in IDLE: no output activity.
- With UART_CMD_ACK_EN, 'X','1','1',CR: tx_byte=0x4B and tx_data_valid pulse, and the uart_tx loopback receives 0x4B. Assert reset mid-frame after 'O','1': all outputs return to 0 immediately and no strobe follows.
